hex_rate_counter: RTL and testbench



---
 rtl/hex_rate_pkg.sv | 22 ++
 rtl/hex_rate_counter_rate_divider.sv | 57 +++++
 rtl/hex_rate_counter.sv | 74 +++++++
 tb/tb_hex_rate_counter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/hex_rate_pkg.sv
// Shared constants for the hex rate counter: speed encodings, count limits and the period helper.
package hex_rate_pkg;

  localparam logic [1:0] SPD_FAST = 2'b00;
  localparam logic [1:0] SPD_1HZ  = 2'b01;
  localparam logic [1:0] SPD_HALF = 2'b10;
  localparam logic [1:0] SPD_QTR  = 2'b11;

  localparam logic [3:0] HEX_MAX = 4'hF;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Divider period in clock cycles for a given speed select.
  function automatic int unsigned period(input logic [1:0] spd, input int unsigned clk_hz);
    case (spd)
      SPD_FAST: return 32'd1;
      SPD_1HZ:  return clk_hz;
      SPD_HALF: return 32'd2 * clk_hz;
      default:  return 32'd4 * clk_hz;
    endcase
  endfunction

endpackage

// File: rtl/hex_rate_counter_rate_divider.sv
// Rate divider: down-counts to the selected period and strobes once per expiry.
module rate_divider
  import hex_rate_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned DIV_W  = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       restart,
  input  logic [1:0] speed,
  output logic       tick,
  output logic       expire_c
);

  logic [DIV_W-1:0] div, div_nxt;
  logic [1:0]       speed_q, speed_q_nxt;
  logic             tick_nxt;

  function automatic logic [DIV_W-1:0] reload(input logic [1:0] spd);
    return DIV_W'(period(spd, CLK_HZ) - 32'd1);
  endfunction

  // A restart (parent load) or speed change re-arms the full period of the new speed.
  always_comb begin
    div_nxt     = div;
    speed_q_nxt = speed_q;
    tick_nxt    = 1'b0;
    expire_c    = 1'b0;
    if (restart || (speed != speed_q)) begin
      div_nxt     = reload(speed);
      speed_q_nxt = speed;
    end else if (enable) begin
      if (div == '0) begin
        div_nxt  = reload(speed_q);
        tick_nxt = 1'b1;
        expire_c = 1'b1;
      end else begin
        div_nxt = div - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div     <= reload(speed);
      speed_q <= speed;
      tick    <= 1'b0;
    end else begin
      div     <= div_nxt;
      speed_q <= speed_q_nxt;
      tick    <= tick_nxt;
    end
  end

endmodule

// File: rtl/hex_rate_counter.sv
// 4-bit rate counter feeding a 7-segment digit, with load and tick/wrap chaining strobes.
// Define HEX_RATE_COUNTER_BCD_EN to count 0..9 instead of 0..F.
module hex_rate_counter
  import hex_rate_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned DIV_W  = 28
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       tick,
  output logic       wrap
);

`ifdef HEX_RATE_COUNTER_BCD_EN
  localparam logic [3:0] CNT_MAX = BCD_MAX;
`else
  localparam logic [3:0] CNT_MAX = HEX_MAX;
`endif

  logic       expire_c;
  logic [3:0] load_val;
  logic [3:0] q_nxt;
  logic       wrap_nxt;

  rate_divider #(
    .CLK_HZ (CLK_HZ),
    .DIV_W  (DIV_W)
  ) u_div (
    .clk      (CLOCK_50),
    .reset    (reset),
    .enable   (enable),
    .restart  (load),
    .speed    (speed),
    .tick     (tick),
    .expire_c (expire_c)
  );

  // Out-of-range load values cannot be shown as a decimal digit, so they clear the count.
  always_comb begin
    load_val = (d > CNT_MAX) ? 4'd0 : d;
  end

  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (load) begin
      q_nxt = load_val;
    end else if (expire_c) begin
      if (q == CNT_MAX) begin
        q_nxt    = 4'd0;
        wrap_nxt = 1'b1;
      end else begin
        q_nxt = q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      q    <= 4'd0;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_hex_rate_counter.sv
// Directed bench for hex_rate_counter with CLK_HZ=4 (periods 1, 4, 8, 16 cycles).
module tb_hex_rate_counter;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       enable   = 1'b0;
  logic [1:0] speed    = 2'b00;
  logic       load     = 1'b0;
  logic [3:0] d        = 4'd0;
  logic [3:0] q;
  logic       tick;
  logic       wrap;

  int n_tests = 0;
  int n_fail  = 0;

  hex_rate_counter #(
    .CLK_HZ (4),
    .DIV_W  (8)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .enable   (enable),
    .speed    (speed),
    .load     (load),
    .d        (d),
    .q        (q),
    .tick     (tick),
    .wrap     (wrap)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] spd, input logic en);
    reset  = 1'b1;
    speed  = spd;
    enable = en;
    load   = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Reset values, then 1 Hz-equivalent rate (P=4).
    do_reset(2'b01, 1'b1);
    check("rst_q", int'(q), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_wrap", int'(wrap), 0);
    for (int c = 1; c <= 12; c++) begin
      step();
      check($sformatf("s01_tick_c%0d", c), int'(tick), (c % 4 == 0) ? 1 : 0);
      check($sformatf("s01_q_c%0d", c), int'(q), c / 4);
      check($sformatf("s01_wrap_c%0d", c), int'(wrap), 0);
    end

    // Fast rate: every cycle ticks, wrap only on F->0.
    do_reset(2'b00, 1'b1);
    for (int c = 1; c <= 17; c++) begin
      step();
      check($sformatf("s00_q_c%0d", c), int'(q), c % 16);
      check($sformatf("s00_tick_c%0d", c), int'(tick), 1);
      check($sformatf("s00_wrap_c%0d", c), int'(wrap), (c == 16) ? 1 : 0);
    end

    // P=8 with a 10-cycle enable pause: tick after 8 enabled cycles, at cycle 18.
    do_reset(2'b10, 1'b1);
    for (int c = 1; c <= 18; c++) begin
      enable = (c >= 5 && c <= 14) ? 1'b0 : 1'b1;
      step();
      check($sformatf("pause_tick_c%0d", c), int'(tick), (c == 18) ? 1 : 0);
      check($sformatf("pause_q_c%0d", c), int'(q), (c == 18) ? 1 : 0);
    end
    enable = 1'b1;

    // Load mid-count at P=16, then next tick a full period later.
    do_reset(2'b11, 1'b1);
    repeat (5) step();
    load = 1'b1;
    d    = 4'hC;
    step();
    load = 1'b0;
    check("load_q", int'(q), 12);
    check("load_tick", int'(tick), 0);
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("ld_tick_k%0d", k), int'(tick), (k == 16) ? 1 : 0);
      check($sformatf("ld_q_k%0d", k), int'(q), (k == 16) ? 13 : 12);
    end

    // Speed change 01->11 three cycles after a tick suppresses the old-rate tick.
    do_reset(2'b01, 1'b1);
    repeat (4) step();
    check("spd_first_tick", int'(tick), 1);
    check("spd_first_q", int'(q), 1);
    repeat (3) step();
    speed = 2'b11;
    step();
    check("spd_chg_tick", int'(tick), 0);
    check("spd_chg_q", int'(q), 1);
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("spd_tick_k%0d", k), int'(tick), (k == 16) ? 1 : 0);
      check($sformatf("spd_q_k%0d", k), int'(q), (k == 16) ? 2 : 1);
    end

    // Load honoured while disabled; counter then holds.
    do_reset(2'b00, 1'b0);
    load = 1'b1;
    d    = 4'h7;
    step();
    load = 1'b0;
    check("ld_dis_q", int'(q), 7);
    repeat (3) step();
    check("hold_q", int'(q), 7);
    check("hold_tick", int'(tick), 0);

    // Reset mid-count discards divider progress (P=4 after reset).
    do_reset(2'b01, 1'b1);
    repeat (2) step();
    do_reset(2'b01, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("rst_mid_tick_c%0d", c), int'(tick), (c == 4) ? 1 : 0);
    end

`ifdef HEX_RATE_COUNTER_BCD_EN
    do_reset(2'b00, 1'b1);
    for (int c = 1; c <= 11; c++) begin
      step();
      check($sformatf("bcd_q_c%0d", c), int'(q), c % 10);
      check($sformatf("bcd_wrap_c%0d", c), int'(wrap), (c == 10) ? 1 : 0);
    end
    load = 1'b1;
    d    = 4'hB;
    step();
    load = 1'b0;
    check("bcd_load_b", int'(q), 0);
`else
    do_reset(2'b00, 1'b0);
    load = 1'b1;
    d    = 4'hB;
    step();
    load = 1'b0;
    check("hex_load_b", int'(q), 11);
    enable = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      check($sformatf("hex_post_ld_q_c%0d", c), int'(q), (11 + c) % 16);
      check($sformatf("hex_post_ld_wrap_c%0d", c), int'(wrap), (c == 5) ? 1 : 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
